motion_detect: RTL and testbench

- Streaming motion detector: compares a background image stream against a current-frame stream pixel by pixel and emits the frame with moving pixels highlighted.
- Sits between the BMP pixel sources (24-bit BGR pixels, raster order) and the output consumer.
- Contains internal FIFOs A (background), B and C (two copies of each frame pixel), a mask FIFO, and an output FIFO. It also contains a grayscale/subtract/threshold stage and a highlight stage.

---
 rtl/motion_detect.sv | 121 ++++++++++++
 tb/tb_motion_detect.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_detect.sv
// motion_detect: streaming motion detector that flags pixels whose gray level moved versus a background stream
// Ports: clock, reset (async, active-low)
//   background_wr_en/background_din : push a BGR background pixel into FIFO A (A_full = back-pressure)
//   frame_wr_en/frame_din           : push a BGR frame pixel into FIFOs B and C together (B_full/C_full)
//   out_rd_en/out_dout/out_empty    : show-ahead output FIFO of highlighted pixels (moving pixels -> pure red)
module motion_detect_fifo #(
  parameter int W = 24,
  parameter int D = 32,
  parameter int CW = $clog2(D) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  din,
  input  logic          rd_en,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, wr, rd;
  assign full = count == CW'(D);
  assign empty = count == '0;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  // forcing zero when empty keeps out_dout at 0 after reset without resetting the storage
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

module motion_detect #(
  parameter int WIDTH = 768,
  parameter int HEIGHT = 576,
  parameter int FIFO_DEPTH = 32,
  parameter int THRESHOLD = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        background_wr_en,
  input  logic [23:0] background_din,
  input  logic        frame_wr_en,
  input  logic [23:0] frame_din,
  output logic        A_full,
  output logic        B_full,
  output logic        C_full,
  input  logic        out_rd_en,
  output logic [23:0] out_dout,
  output logic        out_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  if (WIDTH < 1 || HEIGHT < 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("motion_detect: image size must be positive and FIFO_DEPTH a power of 2 >= 4");
  end
  function automatic logic [7:0] gray(input logic [23:0] p);
    logic [9:0] s;
    s = 10'(p[23:16]) + 10'(p[15:8]) + 10'(p[7:0]);
    return 8'(s / 10'd3);
  endfunction
  logic [23:0] a_dout, b_dout, c_dout, s2_pix;
  logic [CW-1:0] a_cnt, b_cnt, c_cnt, m_cnt, o_cnt;
  logic [7:0] g_bg, g_fr, diff;
  logic m_dout, mask_next, frame_ok, fire1, fire2, s1_valid, s1_mask, s2_valid;
  assign A_full = a_cnt == DEPTH_C;
  assign B_full = b_cnt == DEPTH_C;
  assign C_full = c_cnt == DEPTH_C;
  assign out_empty = o_cnt == '0;
  // B and C must stay in lock-step, so a frame pixel is taken by both or neither
  assign frame_ok = frame_wr_en && !B_full && !C_full;
  // room checks include the registered write still in flight so a stage never overruns its sink
  assign fire1 = a_cnt != '0 && b_cnt != '0 && (m_cnt + CW'(s1_valid)) < DEPTH_C;
  assign fire2 = m_cnt != '0 && c_cnt != '0 && (o_cnt + CW'(s2_valid)) < DEPTH_C;
  assign g_bg = gray(a_dout);
  assign g_fr = gray(b_dout);
  assign diff = g_bg > g_fr ? g_bg - g_fr : g_fr - g_bg;
  assign mask_next = diff > 8'(THRESHOLD);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mask <= 1'b0;
      s2_valid <= 1'b0;
      s2_pix <= '0;
    end else begin
      s1_valid <= fire1;
      s1_mask <= mask_next;
      s2_valid <= fire2;
      s2_pix <= m_dout ? 24'h0000FF : c_dout;
    end
  motion_detect_fifo #(.W(24), .D(FIFO_DEPTH)) u_a (
    .clock(clock), .reset(reset), .wr_en(background_wr_en), .din(background_din),
    .rd_en(fire1), .dout(a_dout), .count(a_cnt)
  );
  motion_detect_fifo #(.W(24), .D(FIFO_DEPTH)) u_b (
    .clock(clock), .reset(reset), .wr_en(frame_ok), .din(frame_din),
    .rd_en(fire1), .dout(b_dout), .count(b_cnt)
  );
  motion_detect_fifo #(.W(24), .D(FIFO_DEPTH)) u_c (
    .clock(clock), .reset(reset), .wr_en(frame_ok), .din(frame_din),
    .rd_en(fire2), .dout(c_dout), .count(c_cnt)
  );
  motion_detect_fifo #(.W(1), .D(FIFO_DEPTH)) u_mask (
    .clock(clock), .reset(reset), .wr_en(s1_valid), .din(s1_mask),
    .rd_en(fire2), .dout(m_dout), .count(m_cnt)
  );
  motion_detect_fifo #(.W(24), .D(FIFO_DEPTH)) u_out (
    .clock(clock), .reset(reset), .wr_en(s2_valid), .din(s2_pix),
    .rd_en(out_rd_en), .dout(out_dout), .count(o_cnt)
  );
endmodule

// File: tb/tb_motion_detect.sv
// tb_motion_detect: randomized and directed bench for motion_detect against a queue-based pixel model
module tb_motion_detect;
  localparam int DEPTH = 32;
  localparam int NPIX = 64 * 48;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic background_wr_en = 1'b0, frame_wr_en = 1'b0, out_rd_en = 1'b0;
  logic [23:0] background_din = '0, frame_din = '0, out_dout;
  logic A_full, B_full, C_full, out_empty;
  int tests = 0, fails = 0, pops = 0;
  logic [23:0] bgq[$], frq[$], expq[$];
  logic [23:0] bg_img [NPIX];
  logic [23:0] fr_img [NPIX];
  logic lit_on = 1'b0;
  logic [23:0] lit = '0, exp_v;
  motion_detect #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .background_wr_en(background_wr_en), .background_din(background_din),
    .frame_wr_en(frame_wr_en), .frame_din(frame_din),
    .A_full(A_full), .B_full(B_full), .C_full(C_full),
    .out_rd_en(out_rd_en), .out_dout(out_dout), .out_empty(out_empty)
  );
  always #5 clock = ~clock;
  function automatic logic [23:0] model(input logic [23:0] bg, input logic [23:0] fr);
    int gb, gf, d;
    gb = (int'(bg[23:16]) + int'(bg[15:8]) + int'(bg[7:0])) / 3;
    gf = (int'(fr[23:16]) + int'(fr[15:8]) + int'(fr[7:0])) / 3;
    d = gb > gf ? gb - gf : gf - gb;
    return d > 50 ? 24'h0000FF : fr;
  endfunction
  function automatic void pair();
    while (bgq.size() != 0 && frq.size() != 0) expq.push_back(model(bgq.pop_front(), frq.pop_front()));
  endfunction
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  task automatic check1(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock)
    if (reset && out_rd_en && !out_empty) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected no pixel", out_dout);
      end else begin
        exp_v = expq.pop_front();
        check("out_dout", out_dout, exp_v);
        if (lit_on) check("literal", out_dout, lit);
        pops++;
      end
    end
  task automatic drain();
    int k;
    out_rd_en = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 4000) begin
      step();
      k++;
    end
    check("drain_left", 24'(expq.size()), 24'd0);
    step();
    step();
    check1("drained_empty", out_empty, 1'b1);
    out_rd_en = 1'b0;
  endtask
  task automatic directed(input logic [23:0] bg, input logic [23:0] fr, input logic [23:0] want, input int n);
    lit_on = 1'b1;
    lit = want;
    for (int i = 0; i < n; i++) begin
      background_wr_en = 1'b1;
      background_din = bg;
      frame_wr_en = 1'b1;
      frame_din = fr;
      bgq.push_back(bg);
      frq.push_back(fr);
      pair();
      step();
    end
    background_wr_en = 1'b0;
    frame_wr_en = 1'b0;
    drain();
    lit_on = 1'b0;
  endtask
  task automatic reset_checks(input string tag);
    check1({tag, "_out_empty"}, out_empty, 1'b1);
    check1({tag, "_A_full"}, A_full, 1'b0);
    check1({tag, "_B_full"}, B_full, 1'b0);
    check1({tag, "_C_full"}, C_full, 1'b0);
    check({tag, "_out_dout"}, out_dout, 24'h0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, k, bs, fs, p0, cyc;
    logic [23:0] p;
    repeat (3) step();
    reset_checks("reset");
    reset = 1'b1;
    step();
    reset_checks("idle");
    // latency: one pixel pair written on a single edge
    background_wr_en = 1'b1;
    background_din = 24'h000000;
    frame_wr_en = 1'b1;
    frame_din = 24'h969696;
    bgq.push_back(24'h000000);
    frq.push_back(24'h969696);
    pair();
    step();
    background_wr_en = 1'b0;
    frame_wr_en = 1'b0;
    lat = 0;
    while (out_empty && lat < 12) begin
      step();
      lat++;
    end
    tests++;
    if (lat > 6) begin
      fails++;
      $display("FAIL latency: got %0d cycles expected <= 6", lat);
    end
    drain();
    directed(24'h336699, 24'h336699, 24'h336699, 4);
    directed(24'h000000, 24'h969696, 24'h0000FF, 4);
    directed(24'h000000, 24'h323232, 24'h323232, 4);
    directed(24'h000000, 24'h333333, 24'h0000FF, 4);
    // back-pressure: frames only, extra writes must be dropped
    for (int i = 1; i <= DEPTH + 8; i++) begin
      frame_wr_en = 1'b1;
      frame_din = {3{8'(i * 7)}};
      if (i <= DEPTH) frq.push_back(frame_din);
      step();
      check1("bp_B_full", B_full, i >= DEPTH);
      check1("bp_C_full", C_full, i >= DEPTH);
    end
    frame_wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check1("bp_A_full", A_full, 1'b0);
      background_wr_en = 1'b1;
      background_din = i[0] ? 24'h141414 : 24'h000000;
      bgq.push_back(background_din);
      pair();
      step();
    end
    background_wr_en = 1'b0;
    repeat (50) step();
    check1("bp_stalled_nonempty", out_empty, 1'b0);
    check1("bp_B_released", B_full, 1'b0);
    check("bp_pending", 24'(expq.size()), 24'(DEPTH));
    p0 = pops;
    drain();
    check("bp_count", 24'(pops - p0), 24'(DEPTH));
    // sustained throughput with reader always ready
    out_rd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      background_wr_en = 1'b1;
      background_din = 24'($urandom);
      frame_wr_en = 1'b1;
      frame_din = $urandom_range(0, 1) ? 24'($urandom) : background_din;
      bgq.push_back(background_din);
      frq.push_back(frame_din);
      pair();
      step();
    end
    background_wr_en = 1'b0;
    frame_wr_en = 1'b0;
    k = 200;
    while (expq.size() != 0 && k < 1000) begin
      step();
      k++;
    end
    tests++;
    if (k > 208) begin
      fails++;
      $display("FAIL throughput: got %0d cycles expected <= 208 for 200 pixels", k);
    end
    drain();
    // reduced-size image pair with random gaps on both writers and the reader
    for (int i = 0; i < NPIX; i++) begin
      bg_img[i] = 24'($urandom);
      case ($urandom_range(0, 2))
        0: fr_img[i] = 24'($urandom);
        1: fr_img[i] = bg_img[i] ^ 24'($urandom_range(0, 63));
        default: fr_img[i] = {3{8'($urandom_range(0, 255))}};
      endcase
    end
    bs = 0;
    fs = 0;
    cyc = 0;
    p0 = pops;
    while ((bs < NPIX || fs < NPIX || expq.size() != 0) && cyc < 40000) begin
      background_wr_en = bs < NPIX && !A_full && $urandom_range(0, 3) != 0;
      if (background_wr_en) begin
        background_din = bg_img[bs];
        bgq.push_back(bg_img[bs]);
        bs++;
      end
      frame_wr_en = fs < NPIX && !B_full && !C_full && $urandom_range(0, 3) != 0;
      if (frame_wr_en) begin
        frame_din = fr_img[fs];
        frq.push_back(fr_img[fs]);
        fs++;
      end
      out_rd_en = $urandom_range(0, 3) != 0;
      pair();
      step();
      cyc++;
    end
    background_wr_en = 1'b0;
    frame_wr_en = 1'b0;
    check("stream_left", 24'(expq.size()), 24'd0);
    check("stream_count", 24'(pops - p0), 24'(NPIX));
    drain();
    // reset mid-stream discards everything buffered
    for (int i = 0; i < DEPTH; i++) begin
      background_wr_en = 1'b1;
      background_din = 24'h000000;
      step();
    end
    background_wr_en = 1'b0;
    check1("pre_reset_A_full", A_full, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      frame_wr_en = 1'b1;
      frame_din = 24'hFFFFFF;
      step();
    end
    frame_wr_en = 1'b0;
    repeat (5) step();
    check1("pre_reset_nonempty", out_empty, 1'b0);
    check1("pre_reset_C_full", C_full, 1'b0);
    reset = 1'b0;
    #1;
    reset_checks("midreset");
    bgq.delete();
    frq.delete();
    expq.delete();
    step();
    step();
    reset = 1'b1;
    out_rd_en = 1'b1;
    repeat (10) step();
    reset_checks("post_reset");
    out_rd_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
